// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM block: command encodings
// and the centre-position helper used for reset and re-centre.
package servo_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD   = 2'b00,
    DIR_CW     = 2'b01,
    DIR_CCW    = 2'b10,
    DIR_CENTER = 2'b11
  } dir_e;

  function automatic int center_pw(input int min_pw, input int max_pw);
    return (min_pw + max_pw) / 2;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: pulse-width register with saturating frame-boundary update,
// registered PWM compare and combinational limit flags.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MIN_PW = 500,
  parameter int MAX_PW = 2500,
  parameter int STEP   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             frame_end,
  input  logic             en,
  input  logic [1:0]       dir,
  output logic             servo,
  output logic [CNT_W-1:0] pw,
  output logic             at_min,
  output logic             at_max
);

  // A step larger than MAX_PW always saturates, so clamping it keeps every
  // operand inside CNT_W+1 bits without changing the result.
  localparam int STEP_C = (STEP > MAX_PW) ? MAX_PW + 1 : STEP;

  localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP_C);
  localparam logic [CNT_W:0]   MIN_X    = (CNT_W+1)'(MIN_PW);
  localparam logic [CNT_W:0]   MAX_X    = (CNT_W+1)'(MAX_PW);
  localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_PW);
  localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_PW);
  localparam logic [CNT_W-1:0] CENTER_V = CNT_W'(center_pw(MIN_PW, MAX_PW));

  logic [CNT_W-1:0] pw_reg, pw_next;
  logic             servo_reg, servo_next;
  logic [CNT_W:0]   pw_ext, sum_ext, diff_ext, floor_ext;

  assign pw_ext    = {1'b0, pw_reg};
  assign sum_ext   = pw_ext + STEP_X;
  assign diff_ext  = pw_ext - STEP_X;
  assign floor_ext = MIN_X + STEP_X;

  always_comb begin
    pw_next = pw_reg;
    if (frame_end && en) begin
      case (dir_e'(dir))
        DIR_HOLD:   pw_next = pw_reg;
        DIR_CW:     pw_next = (sum_ext > MAX_X) ? MAX_V : sum_ext[CNT_W-1:0];
        DIR_CCW:    pw_next = (pw_ext < floor_ext) ? MIN_V : diff_ext[CNT_W-1:0];
        DIR_CENTER: pw_next = CENTER_V;
        default:    pw_next = pw_reg;
      endcase
    end
  end

  // Compare uses the width in force for the current cycle; the lag of one
  // cycle places the pulse at T+1 .. T+pw of each frame.
  assign servo_next = en && (cnt < pw_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_reg    <= CENTER_V;
      servo_reg <= 1'b0;
    end else begin
      pw_reg    <= pw_next;
      servo_reg <= servo_next;
    end
  end

  assign servo  = servo_reg;
  assign pw     = pw_reg;
  assign at_min = (pw_reg == MIN_V);
  assign at_max = (pw_reg == MAX_V);

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM generator: one shared frame counter and frame-start
// pulse driving NUM_CH independent servo_pwm_channel instances.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int PERIOD = 20000,
  parameter int MIN_PW = 500,
  parameter int MAX_PW = 2500,
  parameter int STEP   = 10
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_CH-1:0]       EN,
  input  logic [2*NUM_CH-1:0]     DIR,
  output logic [NUM_CH-1:0]       SERVO,
  output logic [NUM_CH*CNT_W-1:0] PULSE_WIDTH,
  output logic [NUM_CH-1:0]       AT_MIN,
  output logic [NUM_CH-1:0]       AT_MAX,
  output logic                    FRAME_START
);

  if (!((MIN_PW >= 0) && (MIN_PW <= MAX_PW) && (MAX_PW < PERIOD) &&
        (longint'(PERIOD) <= (longint'(1) << CNT_W)) && (STEP >= 1))) begin : g_bad_params
    $fatal(1, "servo_pwm_multi: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             frame_start_reg;
  logic             frame_end;

  assign frame_end = (cnt_reg == LAST_CNT);
  assign cnt_next  = frame_end ? '0 : cnt_reg + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      frame_start_reg <= (cnt_reg == '0);
    end
  end

  assign FRAME_START = frame_start_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    servo_pwm_channel #(
      .CNT_W (CNT_W),
      .MIN_PW(MIN_PW),
      .MAX_PW(MAX_PW),
      .STEP  (STEP)
    ) u_ch (
      .clk      (CLK),
      .rst_n    (RST_N),
      .cnt      (cnt_reg),
      .frame_end(frame_end),
      .en       (EN[gi]),
      .dir      (DIR[2*gi +: 2]),
      .servo    (SERVO[gi]),
      .pw       (PULSE_WIDTH[CNT_W*gi +: CNT_W]),
      .at_min   (AT_MIN[gi]),
      .at_max   (AT_MAX[gi])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi: directed scenarios plus a random
// phase, all checked cycle by cycle against a frame-level behavioural model.
module tb_servo_pwm_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 200;
  localparam int MIN_PW = 10;
  localparam int MAX_PW = 30;
  localparam int STEP   = 5;
  localparam int CENTER = 20;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       en = '0;
  logic [2*NUM_CH-1:0]     dir = '0;
  logic [NUM_CH-1:0]       servo;
  logic [NUM_CH*CNT_W-1:0] pulse_width;
  logic [NUM_CH-1:0]       at_min;
  logic [NUM_CH-1:0]       at_max;
  logic                    frame_start;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position within the frame and the width of each channel.
  int m_cnt = 0;
  int m_pw[NUM_CH];

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD),
    .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .STEP(STEP)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .EN         (en),
    .DIR        (dir),
    .SERVO      (servo),
    .PULSE_WIDTH(pulse_width),
    .AT_MIN     (at_min),
    .AT_MAX     (at_max),
    .FRAME_START(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_pw(input int ch);
    return 32'(pulse_width[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) m_pw[i] = CENTER;
  endtask

  // One clock edge: advance the model from the inputs present before the edge,
  // then compare every output one time unit later.
  task automatic cycle();
    logic [NUM_CH-1:0]   en_v;
    logic [2*NUM_CH-1:0] dir_v;
    logic [NUM_CH-1:0]   exp_servo, exp_min, exp_max;
    int c;
    en_v  = en;
    dir_v = dir;
    c     = m_cnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_servo[i] = en_v[i] && (c < m_pw[i]);
      if (c == PERIOD - 1 && en_v[i]) begin
        case (dir_v[2*i +: 2])
          2'b01:   m_pw[i] = (m_pw[i] + STEP > MAX_PW) ? MAX_PW : m_pw[i] + STEP;
          2'b10:   m_pw[i] = (m_pw[i] - STEP < MIN_PW) ? MIN_PW : m_pw[i] - STEP;
          2'b11:   m_pw[i] = CENTER;
          default: m_pw[i] = m_pw[i];
        endcase
      end
      exp_min[i] = (m_pw[i] == MIN_PW);
      exp_max[i] = (m_pw[i] == MAX_PW);
    end
    m_cnt = (c + 1) % PERIOD;
    chk($sformatf("servo@cnt%0d", c), 32'(servo), 32'(exp_servo));
    chk($sformatf("frame_start@cnt%0d", c), 32'(frame_start), 32'(c == 0));
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("pw%0d@cnt%0d", i, c), dut_pw(i), 32'(m_pw[i]));
    chk("at_min", 32'(at_min), 32'(exp_min));
    chk("at_max", 32'(at_max), 32'(exp_max));
  endtask

  task automatic run_to(input int target);
    while (m_cnt != target) cycle();
  endtask

  task automatic count_frames(input int nframes, output int h0, output int h1, output int fs);
    h0 = 0; h1 = 0; fs = 0;
    for (int k = 0; k < nframes * PERIOD; k++) begin
      cycle();
      h0 += int'(servo[0]);
      h1 += int'(servo[1]);
      fs += int'(frame_start);
    end
  endtask

  initial begin
    int h0, h1, fs;
    int exp0[4];
    int exp1[4];
    exp0 = '{25, 30, 30, 30};
    exp1 = '{15, 10, 10, 10};

    // Reset state
    en  = 2'b11;
    dir = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_servo", 32'(servo), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_pw0", dut_pw(0), 32'(CENTER));
    chk("rst_pw1", dut_pw(1), 32'(CENTER));
    chk("rst_at_min", 32'(at_min), 32'd0);
    chk("rst_at_max", 32'(at_max), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // 1: centred pulses, one frame-start per frame
    count_frames(1, h0, h1, fs);
    chk("s1_high0", 32'(h0), 32'(CENTER));
    chk("s1_high1", 32'(h1), 32'(CENTER));
    chk("s1_fs_count", 32'(fs), 32'd1);

    // 2: ch0 stepping cw, ch1 stepping ccw, both saturating
    dir = 4'b1001;
    for (int f = 0; f < 4; f++) begin
      run_to(PERIOD - 1);
      cycle();
      chk($sformatf("s2_pw0_f%0d", f), dut_pw(0), 32'(exp0[f]));
      chk($sformatf("s2_pw1_f%0d", f), dut_pw(1), 32'(exp1[f]));
      chk($sformatf("s2_at_max0_f%0d", f), 32'(at_max[0]), 32'(f >= 1));
      chk($sformatf("s2_at_min1_f%0d", f), 32'(at_min[1]), 32'(f >= 1));
    end

    // 4a: re-centre from the upper limit
    dir = 4'b0011;
    run_to(PERIOD - 1);
    cycle();
    chk("s4_recentre_pw0", dut_pw(0), 32'(CENTER));
    chk("s4_hold_pw1", dut_pw(1), 32'(MIN_PW));

    // 3: only the command present at the boundary cycle counts
    dir = 4'b0001;
    run_to(100);
    dir = 4'b0010;
    run_to(198);
    dir = 4'b0001;
    run_to(PERIOD - 1);
    cycle();
    chk("s3_pw0", dut_pw(0), 32'(CENTER + STEP));

    dir = 4'b0011;
    run_to(PERIOD - 1);
    cycle();
    chk("s3_recentre_pw0", dut_pw(0), 32'(CENTER));

    // 4b: disabled channel stays silent and keeps its width
    en  = 2'b10;
    dir = 4'b0001;
    count_frames(2, h0, h1, fs);
    chk("s4_off_high0", 32'(h0), 32'd0);
    chk("s4_off_pw0", dut_pw(0), 32'(CENTER));
    chk("s4_on_high1", 32'(h1), 32'(2 * MIN_PW));
    en  = 2'b11;
    dir = 4'b0000;
    count_frames(1, h0, h1, fs);
    chk("s4_resume_high0", 32'(h0), 32'(CENTER));

    // 5: asynchronous reset in the middle of a pulse
    dir = 4'b0001;
    run_to(PERIOD - 1); cycle();
    run_to(PERIOD - 1); cycle();
    chk("s5_pw0_pre", dut_pw(0), 32'(MAX_PW));
    dir = 4'b0000;
    run_to(15);
    chk("s5_servo0_pre", 32'(servo[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s5_servo_async", 32'(servo), 32'd0);
    chk("s5_pw0_async", dut_pw(0), 32'(CENTER));
    chk("s5_pw1_async", dut_pw(1), 32'(CENTER));
    chk("s5_fs_async", 32'(frame_start), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle();
    chk("s5_first_fs", 32'(frame_start), 32'd1);

    // Random commands and enables, including mid-frame EN toggles
    for (int k = 0; k < 8 * PERIOD; k++) begin
      if ($urandom_range(0, 39) == 0) en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) dir = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
